// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, DATA, INSTR, RESP)
//   grant_e     : grant encoding (GRANT_FETCH = 0, GRANT_DATA = 1)
//   DEF_*       : default address/data widths and memory read latency
package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_MEM_LAT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag; times the memory read latency.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   dec        : decrement by one; ignored when already zero
//   zero       : counter value is 0
module mem_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences a single-ported fixed-latency memory shared by instruction fetch
// (IF) and the MEM stage (lw/sw). One access at a time: grant in IDLE, hold
// address/data for MEM_LAT+1 cycles, capture read data, pulse ready in RESP.
//   if_*      : fetch port (req/addr in, rdata/ready out)
//   mem_*     : load/store port (read/write/addr/wdata in, rdata/ready out)
//   stall_*   : combinational per-stage stalls
//   ram_*     : memory side (en strobe one cycle per access, we, addr, wdata;
//               rdata valid MEM_LAT cycles after ram_en)
// Optional macro MEMARB_PERF_EN adds saturating 32-bit stall-cycle counters
// perf_mem_stall / perf_if_stall.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef MEMARB_PERF_EN
    ,
    output logic [31:0]       perf_mem_stall,
    output logic [31:0]       perf_if_stall
`endif
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            gnt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              en_q, en_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic              dreq;

    assign dreq = mem_read | mem_write;

    mem_lat_counter #(.CNT_W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        en_d         = 1'b0;          // strobe lives for exactly one cycle
        mem_rdata_d  = mem_rdata_q;
        if_rdata_d   = if_rdata_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        gnt          = GRANT_FETCH;
        unique case (state_q)
            IDLE: begin
                if (dreq || if_req) begin
                    // On contention alternate, so neither port starves.
                    if (dreq && if_req) begin
                        if (last_grant_q == GRANT_DATA) gnt = GRANT_FETCH;
                        else                            gnt = GRANT_DATA;
                    end else if (dreq) begin
                        gnt = GRANT_DATA;
                    end
                    last_grant_d = gnt;
                    cnt_load     = 1'b1;
                    en_d         = 1'b1;
                    if (gnt == GRANT_DATA) begin
                        addr_d  = mem_addr;
                        wdata_d = mem_wdata;
                        we_d    = mem_write;   // read+write together is a write
                        state_d = DATA;
                    end else begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                        state_d = INSTR;
                    end
                end
            end
            DATA, INSTR: begin
                if (cnt_zero) begin
                    state_d = RESP;
                    if (state_q == INSTR)  if_rdata_d  = ram_rdata;
                    else if (!we_q)        mem_rdata_d = ram_rdata;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            // Always return to IDLE so a requester can drop/advance on ready.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_FETCH;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            en_q         <= 1'b0;
            mem_rdata_q  <= '0;
            if_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            en_q         <= en_d;
            mem_rdata_q  <= mem_rdata_d;
            if_rdata_q   <= if_rdata_d;
        end
    end

    assign ram_en    = en_q;
    // we_q lingers after a store; only expose it while the data access runs.
    assign ram_we    = we_q & (state_q == DATA);
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_ready = (state_q == RESP) && (last_grant_q == GRANT_DATA);
    assign if_ready  = (state_q == RESP) && (last_grant_q == GRANT_FETCH);
    // Gated by rst_n so every output reads 0 while reset is asserted.
    assign stall_mem = rst_n & dreq & ~mem_ready;
    assign stall_if  = rst_n & if_req & ~if_ready;

`ifdef MEMARB_PERF_EN
    logic [31:0] perf_mem_q, perf_mem_d, perf_if_q, perf_if_d;

    always_comb begin
        perf_mem_d = perf_mem_q;
        perf_if_d  = perf_if_q;
        if (stall_mem && (perf_mem_q != 32'hFFFF_FFFF)) perf_mem_d = perf_mem_q + 32'd1;
        if (stall_if  && (perf_if_q  != 32'hFFFF_FFFF)) perf_if_d  = perf_if_q  + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_mem_q <= '0;
            perf_if_q  <= '0;
        end else begin
            perf_mem_q <= perf_mem_d;
            perf_if_q  <= perf_if_d;
        end
    end

    assign perf_mem_stall = perf_mem_q;
    assign perf_if_stall  = perf_if_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with MEM_LAT = 2.
// A small RAM model returns read data exactly two cycles after ram_en and
// drives a poison value otherwise, so mistimed captures show up.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if, stall_mem;
    logic        ram_en, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
`ifdef MEMARB_PERF_EN
    logic [31:0] perf_mem_stall, perf_if_stall;
    logic [31:0] perf0;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef MEMARB_PERF_EN
        ,
        .perf_mem_stall (perf_mem_stall),
        .perf_if_stall  (perf_if_stall)
`endif
    );

    // RAM model: 256 words, two-cycle read pipeline.
    logic [31:0] ram [0:255];
    logic [31:0] rd_p0 = 32'h0BAD_0000;
    logic [31:0] rd_p1 = 32'h0BAD_0000;
    assign ram_rdata = rd_p1;

    always @(posedge clk) begin
        if (ram_en && !ram_we) rd_p0 <= ram[ram_addr[9:2]];
        else                   rd_p0 <= 32'h0BAD_0000;
        rd_p1 <= rd_p0;
        if (ram_en && ram_we) ram[ram_addr[9:2]] <= ram_wdata;
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Per-run observations (cycle 0 = cycle the request is first presented).
    int          cyc, mem_rdy_at, if_rdy_at, mstall, istall, n_en;
    logic [31:0] en_addr [4];
    logic        en_we   [4];
    logic [31:0] en_wd   [4];
    int          en_at   [4];
    logic [31:0] got_mrd, got_ird;

    // Sample at negedge, step inputs #1 after posedge. Without hold, each
    // port drops its request the cycle after its ready pulse; with hold the
    // requests stay up until stop_en accesses have started.
    task automatic run(input bit hold, input int stop_en, input int budget);
        bit saw_m, saw_i, done;
        cyc = 0; mem_rdy_at = -1; if_rdy_at = -1;
        mstall = 0; istall = 0; n_en = 0; done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            if (stall_mem) mstall++;
            if (stall_if)  istall++;
            if (ram_en && n_en < 4) begin
                en_addr[n_en] = ram_addr; en_we[n_en] = ram_we;
                en_wd[n_en] = ram_wdata;  en_at[n_en] = cyc;
                n_en++;
            end
            saw_m = mem_ready;
            saw_i = if_ready;
            if (saw_m && mem_rdy_at < 0) begin mem_rdy_at = cyc; got_mrd = mem_rdata; end
            if (saw_i && if_rdy_at < 0)  begin if_rdy_at = cyc;  got_ird = if_rdata;  end
            @(posedge clk); #1;
            cyc++;
            if (!hold) begin
                if (saw_m) begin mem_read = 1'b0; mem_write = 1'b0; end
                if (saw_i) if_req = 1'b0;
                done = !mem_read && !mem_write && !if_req;
            end else begin
                done = (n_en >= stop_en);
            end
        end
        chk("run_in_budget", 32'(done), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h10] = 32'hDEAD_BEEF;   // 0x40
        ram[8'h11] = 32'hCAFE_F00D;   // 0x44
        ram[8'h12] = 32'h0BAD_CAFE;   // 0x48
        ram[8'h40] = 32'h0000_0013;   // 0x100
        ram[8'h41] = 32'h0010_0093;   // 0x104

        // Reset state
        #12;
        chk("rst_ram_en",    32'(ram_en),    32'd0);
        chk("rst_ram_we",    32'(ram_we),    32'd0);
        chk("rst_ram_addr",  ram_addr,       32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_if_ready",  32'(if_ready),  32'd0);
        chk("rst_mem_rdata", mem_rdata,      32'd0);
        chk("rst_if_rdata",  if_rdata,       32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single lw 0x40
        mem_read = 1'b1; mem_addr = 32'h40;
        run(1'b0, 0, 20);
        chk("lw_ready_cyc", 32'(mem_rdy_at), 32'd4);
        chk("lw_stall_cyc", 32'(mstall),     32'd4);
        chk("lw_n_en",      32'(n_en),       32'd1);
        chk("lw_en_cyc",    32'(en_at[0]),   32'd1);
        chk("lw_we",        32'(en_we[0]),   32'd0);
        chk("lw_addr",      en_addr[0],      32'h40);
        chk("lw_rdata",     got_mrd,         32'hDEAD_BEEF);

        // Single sw 0x80
`ifdef MEMARB_PERF_EN
        perf0 = perf_mem_stall;
`endif
        mem_write = 1'b1; mem_addr = 32'h80; mem_wdata = 32'h1234_5678;
        run(1'b0, 0, 20);
        chk("sw_ready_cyc", 32'(mem_rdy_at), 32'd4);
        chk("sw_n_en",      32'(n_en),       32'd1);
        chk("sw_we",        32'(en_we[0]),   32'd1);
        chk("sw_wdata",     en_wd[0],        32'h1234_5678);
        chk("sw_addr",      en_addr[0],      32'h80);
        chk("sw_rdata_held", mem_rdata,      32'hDEAD_BEEF);
`ifdef MEMARB_PERF_EN
        chk("sw_perf_mem",  perf_mem_stall - perf0, 32'd4);
`endif

        // Read back the stored word
        mem_read = 1'b1; mem_addr = 32'h80;
        run(1'b0, 0, 20);
        chk("rb_rdata", got_mrd, 32'h1234_5678);

        // Reset in the middle of a data access
        mem_read = 1'b1; mem_addr = 32'h40;
        @(posedge clk); #1;
        chk("mid_pre_en", 32'(ram_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_ram_en",    32'(ram_en),    32'd0);
        chk("mid_ram_addr",  ram_addr,       32'd0);
        chk("mid_stall_mem", 32'(stall_mem), 32'd0);
        chk("mid_mem_rdata", mem_rdata,      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mem_read = 1'b0;
        begin
            int rdy_cnt = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (mem_ready || if_ready) rdy_cnt++;
            end
            chk("mid_no_ready", 32'(rdy_cnt), 32'd0);
        end
        @(posedge clk); #1;

        // Simultaneous fetch + lw right after reset: data first
        if_req = 1'b1; if_addr = 32'h100;
        mem_read = 1'b1; mem_addr = 32'h44;
        run(1'b0, 0, 30);
        chk("sim_mem_ready", 32'(mem_rdy_at), 32'd4);
        chk("sim_if_ready",  32'(if_rdy_at),  32'd9);
        chk("sim_first",     en_addr[0],      32'h44);
        chk("sim_second",    en_addr[1],      32'h100);
        chk("sim_mrdata",    got_mrd,         32'hCAFE_F00D);
        chk("sim_irdata",    got_ird,         32'h0000_0013);
        chk("sim_if_stall",  32'(istall),     32'd9);

        // Continuous contention: last grant was FETCH -> DATA, FETCH, DATA
        if_req = 1'b1; if_addr = 32'h104;
        mem_read = 1'b1; mem_addr = 32'h48;
        run(1'b1, 3, 40);
        chk("rr_g0",      en_addr[0], 32'h48);
        chk("rr_g1",      en_addr[1], 32'h104);
        chk("rr_g2",      en_addr[2], 32'h48);
        chk("rr_spacing", 32'(en_at[1] - en_at[0]), 32'd5);
        if_req = 1'b0; mem_read = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Read and write together count as a write
`ifdef MEMARB_PERF_EN
        perf0 = perf_mem_stall;
`endif
        mem_read = 1'b1; mem_write = 1'b1;
        mem_addr = 32'h84; mem_wdata = 32'hA5A5_A5A5;
        run(1'b0, 0, 20);
        chk("rw_we",    32'(en_we[0]),   32'd1);
        chk("rw_ready", 32'(mem_rdy_at), 32'd4);
        chk("rw_ram",   ram[8'h21],      32'hA5A5_A5A5);
`ifdef MEMARB_PERF_EN
        chk("rw_perf_mem", perf_mem_stall - perf0, 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
